// File: rtl/yarp_lsu.sv
// yarp_lsu: load/store unit issuing one word-aligned access per request on a valid/grant/rvalid bus.
// Optional YARP_LSU_MISALIGN_TRAP_EN rejects misaligned requests instead of force-aligning them.
module yarp_lsu #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_zero_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Last counter value seen in WAIT before the response is declared lost.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  logic [1:0]           state_r;
  logic [1:0]           off_r;
  logic [1:0]           size_r;
  logic                 zext_r;
  logic [TIMEOUT_W-1:0] cnt_r;
  logic [1:0]           req_off_s;
  logic [1:0]           req_size_s;
`ifdef YARP_LSU_MISALIGN_TRAP_EN
  logic                 req_mis_s;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction
`endif

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   calc_be = 4'b0001 << off;
      2'b01:   calc_be = 4'b0011 << off;
      default: calc_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   calc_wdata = {4{wd[7:0]}};
      2'b01:   calc_wdata = {2{wd[15:0]}};
      default: calc_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic zext,
                                              input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'b00:   extend_load = zext ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extend_load = zext ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extend_load = sh;
    endcase
  endfunction

  assign busy_o = (state_r != ST_IDLE);

  // Decode the incoming request's effective offset and size.
  always_comb begin
    req_off_s  = addr_i[1:0];
    req_size_s = mem_size_i;
`ifdef YARP_LSU_MISALIGN_TRAP_EN
    req_mis_s  = is_misaligned(mem_size_i, addr_i[1:0]);
`else
    case (mem_size_i)
      2'b00: req_off_s = addr_i[1:0];
      2'b01: req_off_s = {addr_i[1], 1'b0};
      default: begin
        req_off_s  = 2'b00;
        req_size_s = 2'b10;
      end
    endcase
`endif
  end

  // Request FSM with registered bus and completion outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      off_r       <= 2'b00;
      size_r      <= 2'b00;
      zext_r      <= 1'b0;
      cnt_r       <= '0;
      done_o      <= 1'b0;
      rdata_o     <= 32'h0000_0000;
      err_o       <= 1'b0;
      misalign_o  <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_addr_o  <= 32'h0000_0000;
      bus_we_o    <= 1'b0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= 32'h0000_0000;
    end else begin
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      misalign_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mem_req_i) begin
`ifdef YARP_LSU_MISALIGN_TRAP_EN
            if (req_mis_s) begin
              done_o     <= 1'b1;
              misalign_o <= 1'b1;
              rdata_o    <= 32'h0000_0000;
            end else
`endif
            begin
              state_r     <= ST_REQ;
              off_r       <= req_off_s;
              size_r      <= req_size_s;
              zext_r      <= mem_zero_ext_i;
              bus_req_o   <= 1'b1;
              bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus_we_o    <= mem_we_i;
              bus_be_o    <= calc_be(req_size_s, req_off_s);
              bus_wdata_o <= calc_wdata(req_size_s, wdata_i);
            end
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            if (bus_we_o) begin
              state_r <= ST_IDLE;
              done_o  <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= '0;
            end
          end
        end
        ST_WAIT: begin
          // A response arriving on the last allowed cycle still wins over the timeout.
          if (bus_rvalid_i) begin
            rdata_o <= extend_load(size_r, zext_r, off_r, bus_rdata_i);
            done_o  <= 1'b1;
            state_r <= ST_IDLE;
          end else if (cnt_r == CNT_LAST) begin
            rdata_o <= 32'h0000_0000;
            err_o   <= 1'b1;
            done_o  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + TIMEOUT_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yarp_lsu.sv
// Directed, table-driven bench for yarp_lsu (TIMEOUT_W=4); honours YARP_LSU_MISALIGN_TRAP_EN.
module tb_yarp_lsu;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [1:0]  mem_size_i = 2'b00;
  logic        mem_zero_ext_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        busy_o, done_o, err_o, misalign_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_we_o;
  logic        bus_gnt_i = 1'b0;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'h0;

  int checks = 0;
  int failures = 0;

  yarp_lsu #(.TIMEOUT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_zero_ext_i(mem_zero_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .misalign_o(misalign_o), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gw;      // extra cycles before grant
    int          rw;      // extra cycles before rvalid
    logic [31:0] rdata;
    logic        e_mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue at the current negedge (cycle 0); returns at the negedge of the completion cycle.
  task automatic run_vec(input vec_t v);
    mem_req_i = 1'b1;
    mem_we_i = v.we;
    mem_size_i = v.size;
    mem_zero_ext_i = v.zext;
    addr_i = v.addr;
    wdata_i = v.wdata;
    @(negedge clk);
    mem_req_i = 1'b0;
    addr_i = 32'hFFFF_FFFF;
    wdata_i = 32'h5A5A_5A5A;
    if (v.e_mis) begin
      chk("mis_done", {31'h0, done_o}, 32'h1);
      chk("mis_flag", {31'h0, misalign_o}, 32'h1);
      chk("mis_rdata", rdata_o, 32'h0);
      chk("mis_no_req", {31'h0, bus_req_o}, 32'h0);
      chk("mis_busy", {31'h0, busy_o}, 32'h0);
    end else begin
      chk("done_width", {31'h0, done_o}, 32'h0);
      chk("req_up", {31'h0, bus_req_o}, 32'h1);
      chk("busy_req", {31'h0, busy_o}, 32'h1);
      chk("bus_addr", bus_addr_o, v.e_addr);
      chk("bus_be", {28'h0, bus_be_o}, {28'h0, v.e_be});
      chk("bus_we", {31'h0, bus_we_o}, {31'h0, v.we});
      if (v.we) chk("bus_wdata", bus_wdata_o, v.e_wdata);
      else chk("load_no_mis", {31'h0, misalign_o}, 32'h0);
      for (int k = 0; k < v.gw; k++) begin
        @(negedge clk);
        chk("req_hold", {31'h0, bus_req_o}, 32'h1);
        chk("addr_hold", bus_addr_o, v.e_addr);
      end
      bus_gnt_i = 1'b1;
      @(negedge clk);
      bus_gnt_i = 1'b0;
      chk("req_drop", {31'h0, bus_req_o}, 32'h0);
      if (v.we) begin
        chk("st_done", {31'h0, done_o}, 32'h1);
        chk("st_busy", {31'h0, busy_o}, 32'h0);
        chk("st_err", {31'h0, err_o}, 32'h0);
      end else begin
        for (int k = 0; k < v.rw; k++) begin
          chk("wait_nodone", {31'h0, done_o}, 32'h0);
          chk("wait_busy", {31'h0, busy_o}, 32'h1);
          @(negedge clk);
        end
        bus_rvalid_i = 1'b1;
        bus_rdata_i = v.rdata;
        @(negedge clk);
        bus_rvalid_i = 1'b0;
        bus_rdata_i = 32'hDEAD_0000;
        chk("ld_done", {31'h0, done_o}, 32'h1);
        chk("ld_rdata", rdata_o, v.e_rdata);
        chk("ld_err", {31'h0, err_o}, 32'h0);
        chk("ld_busy", {31'h0, busy_o}, 32'h0);
      end
    end
  endtask

  initial begin
    //           we    size   zx    addr          wdata         gw rw rdata         mis   e_addr        e_be     e_wdata       e_rdata
    vecs[0] = '{1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0,        1'b0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[1] = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_BEEF, 0, 0, 32'h0,        1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[2] = '{1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 2, 0, 32'h0,        1'b0, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[3] = '{1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,         1, 1, 32'h8001_1234, 1'b0, 32'h0000_2000, 4'b1100, 32'h0,         32'hFFFF_8001};
    vecs[4] = '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,         1, 1, 32'h8001_1234, 1'b0, 32'h0000_2000, 4'b1100, 32'h0,         32'h0000_8001};
    vecs[5] = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         0, 0, 32'h00FF_EE00, 1'b0, 32'h0000_0010, 4'b0010, 32'h0,         32'h0000_00EE};
    vecs[6] = '{1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0,         0, 0, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vecs[7] = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,         0, 3, 32'h1234_5678, 1'b0, 32'h0000_0040, 4'b1111, 32'h0,         32'h1234_5678};
`ifdef YARP_LSU_MISALIGN_TRAP_EN
    vecs[8] = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         0, 0, 32'hCAFE_F00D, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[9] = '{1'b1, 2'b11, 1'b0, 32'h0000_0009, 32'h0102_0304, 0, 0, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
`else
    vecs[8] = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         0, 0, 32'hCAFE_F00D, 1'b0, 32'h0000_0004, 4'b1111, 32'h0,         32'hCAFE_F00D};
    vecs[9] = '{1'b1, 2'b11, 1'b0, 32'h0000_0009, 32'h0102_0304, 0, 0, 32'h0,        1'b0, 32'h0000_0008, 4'b1111, 32'h0102_0304, 32'h0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_req", {31'h0, bus_req_o}, 32'h0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_be", {28'h0, bus_be_o}, 32'h0);
    chk("rst_wdata", bus_wdata_o, 32'h0);
    chk("rst_flags", {29'h0, err_o, misalign_o, bus_we_o}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each vector issues in the completion cycle of the previous one.
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Response timeout: 15 WAIT cycles, then err with done; late rvalid ignored.
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_zero_ext_i = 1'b0;
    addr_i = 32'h0000_0020;
    @(negedge clk);
    mem_req_i = 1'b0;
    chk("rvalid_in_req_ignored", {31'h0, bus_req_o}, 32'h1);
    bus_gnt_i = 1'b1;
    @(negedge clk);
    bus_gnt_i = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("to_nodone", {31'h0, done_o}, 32'h0);
      @(negedge clk);
    end
    chk("to_done", {31'h0, done_o}, 32'h1);
    chk("to_err", {31'h0, err_o}, 32'h1);
    chk("to_rdata", rdata_o, 32'h0);
    chk("to_busy", {31'h0, busy_o}, 32'h0);
    bus_rvalid_i = 1'b1;
    bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_rvalid_i = 1'b0;
    chk("late_done", {31'h0, done_o}, 32'h0);
    chk("late_err", {31'h0, err_o}, 32'h0);
    chk("late_busy", {31'h0, busy_o}, 32'h0);
    chk("late_rdata", rdata_o, 32'h0);

    // Reset while in REQ drops bus_req_o/busy_o immediately.
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b00;
    addr_i = 32'h0000_0008; wdata_i = 32'h0000_0055;
    @(negedge clk);
    mem_req_i = 1'b0;
    chk("pre_rst_req", {31'h0, bus_req_o}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, bus_req_o}, 32'h0);
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_addr", bus_addr_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0]);
    @(negedge clk);
    chk("final_done_width", {31'h0, done_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
